// File: rtl/shift_add_datapath.sv
// shift_add_datapath: M/C/A/Q registers of an n-bit shift-and-add multiplier with a product capture register
module shift_add_datapath #(
    parameter int n = 4
) (
    input  logic           clock,
    input  logic           n_reset,
    input  logic [n-1:0]   multiplicand,
    input  logic [n-1:0]   multiplier,
    input  logic           load,
    input  logic           add_shift,
    input  logic           shift,
    input  logic           ready,
    output logic           Q0,
    output logic [2*n-1:0] product,
    output logic           result_valid
);
    logic [n-1:0] m, a, q;
    logic         c, ready_d;
    logic [n:0]   sum;

    assign sum = {1'b0, a} + {1'b0, m};
    assign Q0  = q[0];

    // Operand/accumulator registers: load beats add_shift beats shift; the add carry lands in A's MSB
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            m <= '0;
            a <= '0;
            q <= '0;
            c <= 1'b0;
        end else if (load) begin
            m <= multiplicand;
            q <= multiplier;
            a <= '0;
            c <= 1'b0;
        end else if (add_shift) begin
            a <= sum[n:1];
            q <= {sum[0], q[n-1:1]};
            c <= 1'b0;
        end else if (shift) begin
            a <= {c, a[n-1:1]};
            q <= {a[0], q[n-1:1]};
            c <= 1'b0;
        end
    end

    // Capture pre-edge {A,Q} on the rising edge of ready, so a same-edge reload cannot corrupt it
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            ready_d      <= 1'b0;
            product      <= '0;
            result_valid <= 1'b0;
        end else begin
            ready_d      <= ready;
            result_valid <= ready && !ready_d;
            if (ready && !ready_d)
                product <= {a, q};
        end
    end
endmodule

// File: tb/tb_shift_add_datapath.sv
// tb_shift_add_datapath: directed and random multiplier runs checked against plain arithmetic
module tb_shift_add_datapath;
    localparam int N = 4;

    logic           clock = 1'b0;
    logic           n_reset = 1'b0;
    logic [N-1:0]   multiplicand = '0;
    logic [N-1:0]   multiplier = '0;
    logic           load = 1'b0;
    logic           add_shift = 1'b0;
    logic           shift = 1'b0;
    logic           ready = 1'b0;
    logic           Q0;
    logic [2*N-1:0] product;
    logic           result_valid;

    int compared = 0;
    int mismatched = 0;

    shift_add_datapath #(.n(N)) dut (
        .clock(clock),
        .n_reset(n_reset),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .load(load),
        .add_shift(add_shift),
        .shift(shift),
        .ready(ready),
        .Q0(Q0),
        .product(product),
        .result_valid(result_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_ops(input logic [N-1:0] mc, input logic [N-1:0] mp, input bit junk);
        multiplicand = mc;
        multiplier   = mp;
        load = 1'b1;
        ready = 1'b0;
        add_shift = junk;
        shift = junk;
        step();
        load = 1'b0;
        add_shift = 1'b0;
        shift = 1'b0;
    endtask

    // Sequencer behaviour: add_shift on a multiplier 1 bit, shift on a 0 bit; Q0 must show those bits LSB first
    task automatic shifts(input logic [N-1:0] mp, input int cnt, input bit both);
        for (int i = 0; i < cnt; i++) begin
            chk($sformatf("q0_bit%0d", i), Q0, mp[i]);
            add_shift = mp[i];
            shift = !mp[i] || both;
            step();
        end
        add_shift = 1'b0;
        shift = 1'b0;
    endtask

    task automatic capture(input logic [2*N-1:0] exp);
        ready = 1'b1;
        step();
        chk("product", product, exp);
        chk("valid_pulse", result_valid, 1'b1);
        step();
        chk("valid_drop", result_valid, 1'b0);
        chk("product_hold", product, exp);
    endtask

    task automatic run(input logic [N-1:0] mc, input logic [N-1:0] mp, input bit junk, input bit both);
        logic [2*N-1:0] exp;
        exp = mc * mp;
        load_ops(mc, mp, junk);
        shifts(mp, N, both);
        capture(exp);
    endtask

    initial begin
        #2;
        chk("rst_q0", Q0, 1'b0);
        chk("rst_product", product, '0);
        chk("rst_valid", result_valid, 1'b0);
        step();
        n_reset = 1'b1;
        step();
        chk("idle_q0", Q0, 1'b0);

        run(4'd13, 4'd11, 1'b0, 1'b0);
        run(4'd15, 4'd15, 1'b0, 1'b0);
        run(4'd0, 4'd9, 1'b0, 1'b0);
        run(4'd9, 4'd0, 1'b0, 1'b0);
        run(4'd10, 4'd6, 1'b1, 1'b0);
        run(4'd11, 4'd13, 1'b0, 1'b1);

        // Capture edge coincides with a reload held for 5 cycles
        load_ops(4'd13, 4'd11, 1'b0);
        shifts(4'd11, N, 1'b0);
        multiplicand = 4'd6;
        multiplier = 4'd7;
        load = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("hold_valid%0d", k), result_valid, k == 0);
            chk($sformatf("hold_product%0d", k), product, 8'h8F);
        end
        load = 1'b0;
        ready = 1'b0;
        shifts(4'd7, N, 1'b0);
        capture(8'd42);

        // Asynchronous reset mid-run clears without a clock edge
        load_ops(4'd13, 4'd11, 1'b0);
        shifts(4'd11, 2, 1'b0);
        #3;
        n_reset = 1'b0;
        #1;
        chk("arst_q0", Q0, 1'b0);
        chk("arst_product", product, '0);
        chk("arst_valid", result_valid, 1'b0);
        step();
        n_reset = 1'b1;
        run(4'd3, 4'd5, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++)
            run(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
